fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 76 +++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, one in-flight memory read and a one-entry
// skid buffer that absorbs the read already issued when downstream stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    logic [31:0] pc;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        skid_valid;
    logic [31:0] skid_data;
    logic [31:0] skid_pc;
    logic        out_ready;
    logic        issue;

    assign mem_addr  = pc;
    assign out_ready = !instr_valid || !stall;
    // Only fetch when the result has somewhere to land next cycle.
    assign issue     = out_ready || (!f_valid && !skid_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            f_valid     <= 1'b0;
            f_pc        <= 32'h0;
            skid_valid  <= 1'b0;
            skid_data   <= 32'h0;
            skid_pc     <= 32'h0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else if (branch_taken) begin
            pc          <= branch_target & ~32'h3;
            f_valid     <= 1'b0;
            skid_valid  <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            if (issue) begin
                f_valid <= 1'b1;
                f_pc    <= pc;
                pc      <= pc + 32'd4;
            end else begin
                f_valid <= 1'b0;
            end

            if (out_ready) begin
                if (skid_valid) begin
                    instr       <= skid_data;
                    instr_pc    <= skid_pc;
                    instr_valid <= 1'b1;
                    skid_valid  <= 1'b0;
                end else begin
                    instr       <= mem_data;
                    instr_pc    <= f_pc;
                    instr_valid <= f_valid;
                end
            end else if (f_valid) begin
                skid_data  <= mem_data;
                skid_pc    <= f_pc;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule
